// File: rtl/matrix_multiplier_nxn_pkg.sv
// Package mm_pkg: shared definitions for the N x N matrix multiplier.
// Contents:
//   mmState_e   - controller states IDLE / LOAD / CALC
//   clog2       - ceiling log2 usable in constant expressions
//   atLeastOne  - clamps a width to a minimum of one bit
//   outWidth    - result width 2*DATA_W + clog2(N), wide enough that a full
//                 dot product of N terms never overflows
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } mmState_e;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Counters and indexes must have at least one bit even when N is 1.
    function automatic int atLeastOne(input int width);
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int outWidth(input int n, input int dataW);
        return 2 * dataW + clog2(n);
    endfunction

endpackage

// File: rtl/matrix_multiplier_nxn_mac.sv
// mm_mac: registered multiply-accumulate used serially by the matrix multiplier.
// Ports:
//   clk_i   - clock, rising edge
//   nrst_i  - synchronous active-low reset, clears the accumulator
//   clr_i   - start a new sum: the current product replaces the old total
//   en_i    - update the accumulator register at this edge
//   a_i     - multiplicand, DATA_W bits
//   b_i     - multiplier, DATA_W bits
//   acc_o   - running sum including the current product (OUT_W bits); this is
//             the value the accumulator register takes at the next enabled edge
// Configuration: when MM_SIGNED_EN is defined the operands and sum are two's
// complement; otherwise everything is unsigned.
module mm_mac #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 17
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [OUT_W-1:0]  acc_o
);

    logic [OUT_W-1:0] aExt;
    logic [OUT_W-1:0] bExt;
    logic [OUT_W-1:0] product;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] acc_q;

    // Operands are extended to the full result width before multiplying. The
    // true product always fits in OUT_W bits, so the low OUT_W bits of the
    // extended product are exact for both signed and unsigned operands.
`ifdef MM_SIGNED_EN
    assign aExt = {{(OUT_W-DATA_W){a_i[DATA_W-1]}}, a_i};
    assign bExt = {{(OUT_W-DATA_W){b_i[DATA_W-1]}}, b_i};
`else
    assign aExt = {{(OUT_W-DATA_W){1'b0}}, a_i};
    assign bExt = {{(OUT_W-DATA_W){1'b0}}, b_i};
`endif

    // The next accumulator value is also the output, so the controller can
    // register a finished dot product in the same edge as its last term.
    always_comb begin
        product = aExt * bExt;
        acc_d   = (clr_i ? '0 : acc_q) + product;
        acc_o   = acc_d;
    end

    // Accumulator register, only advanced while the controller is calculating.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_multiplier_nxn.sv
// matrix_multiplier_nxn: serial N x N integer matrix multiplier, C = A x B.
// Operands arrive one A/B element pair per clock in row-major order; C is
// produced on a single shared MAC and streamed out row-major with a one-cycle
// strobe per element.
// Ports:
//   clk_i         - clock, rising edge
//   nrst_i        - synchronous active-low reset (discards any job in flight)
//   start_i       - begin a job; only sampled while idle
//   a_i, b_i      - A and B elements, DATA_W bits each
//   busy_o        - high while loading or calculating
//   out_o         - current C element, OUT_W bits, held between strobes
//   out_strobe_o  - one-cycle pulse marking a new C element on out_o
// Configuration: define MM_SIGNED_EN for two's complement operands and results.
module matrix_multiplier_nxn
    import mm_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int OUT_W  = outWidth(N, DATA_W)
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [OUT_W-1:0]  out_o,
    output logic              out_strobe_o
);

    localparam int AW = atLeastOne(clog2(N * N));
    localparam int CW = atLeastOne(clog2(N));
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    mmState_e          state_q;
    logic [AW-1:0]     loadIdx_q;
    logic [CW-1:0]     iCnt_q;
    logic [CW-1:0]     jCnt_q;
    logic [CW-1:0]     kCnt_q;
    logic [OUT_W-1:0]  out_q;
    logic              strobe_q;
    logic              busy_q;

    logic [DATA_W-1:0] aStore_q [N*N];
    logic [DATA_W-1:0] bStore_q [N*N];

    logic              storeEn;
    logic [AW-1:0]     storeIdx;
    logic [AW-1:0]     aIdx;
    logic [AW-1:0]     bIdx;
    logic [OUT_W-1:0]  macAcc;

    // Element 0 is captured on the START edge itself, the rest while loading.
    always_comb begin
        storeEn  = nrst_i && (((state_q == IDLE) && start_i) || (state_q == LOAD));
        storeIdx = (state_q == IDLE) ? '0 : loadIdx_q;
        aIdx     = AW'(int'(iCnt_q) * N + int'(kCnt_q));
        bIdx     = AW'(int'(kCnt_q) * N + int'(jCnt_q));
    end

    // Operand storage is deliberately left out of reset; a new job always
    // overwrites every element before it is read.
    always_ff @(posedge clk_i) begin
        if (storeEn) begin
            aStore_q[storeIdx] <= a_i;
            bStore_q[storeIdx] <= b_i;
        end
    end

    mm_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .clr_i  (kCnt_q == '0),
        .en_i   (state_q == CALC),
        .a_i    (aStore_q[aIdx]),
        .b_i    (bStore_q[bIdx]),
        .acc_o  (macAcc)
    );

    // Controller: load N*N pairs, then walk i, j, k (k innermost) with one MAC
    // step per edge. The finished sum is registered at the k == N-1 step, so
    // the strobe appears in the following cycle; leaving CALC on the very last
    // step makes busy fall in the same cycle as the final strobe, which lets a
    // new START be accepted right then.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= IDLE;
            loadIdx_q <= '0;
            iCnt_q    <= '0;
            jCnt_q    <= '0;
            kCnt_q    <= '0;
            out_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        iCnt_q <= '0;
                        jCnt_q <= '0;
                        kCnt_q <= '0;
                        if (N == 1) begin
                            state_q   <= CALC;
                            loadIdx_q <= '0;
                        end else begin
                            state_q   <= LOAD;
                            loadIdx_q <= AW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (loadIdx_q == LAST_IDX) begin
                        state_q   <= CALC;
                        loadIdx_q <= '0;
                    end else begin
                        loadIdx_q <= loadIdx_q + AW'(1);
                    end
                end
                CALC: begin
                    if (kCnt_q == LAST_CNT) begin
                        kCnt_q   <= '0;
                        out_q    <= macAcc;
                        strobe_q <= 1'b1;
                        if (jCnt_q == LAST_CNT) begin
                            jCnt_q <= '0;
                            if (iCnt_q == LAST_CNT) begin
                                iCnt_q  <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                iCnt_q <= iCnt_q + CW'(1);
                            end
                        end else begin
                            jCnt_q <= jCnt_q + CW'(1);
                        end
                    end else begin
                        kCnt_q <= kCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign out_o        = out_q;
    assign out_strobe_o = strobe_q;

endmodule
